rx_frame_ctrl: RTL and testbench
================================

# rx_frame_ctrl

Frame-level controller for the serial DSKY/axis input link. It watches the same byte stream as the `rx_conn` parser and checks each frame's character classes and length. It aborts and clears the parser on malformed or stalled frames, and atomically commits complete frames into AGC-visible input registers. A req/ack handshake hands each committed frame to the AGC I/O logic.

## Interface
Parameters:
- FRAME_LEN, 29: bytes per frame. Layout is '<', 2 VERB digits, 2 NOUN digits, then AXIG/AXIRA/AXIRB/AXIATX, each as 5 octal digits followed by a sign ('+'/'-').
- TIMEOUT_CYCLES, 1_000_000: maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- RX_byte  in  8  received ASCII byte, qualified by RX_valid
- RX_valid  in  1  one-cycle strobe per received byte
- parser_data  in  [5:0][5:0][2:0]  parser outputs; index 0..5 = VERB, NOUN, AXIG, AXIRA, AXIRB, AXIATX
- parser_clear  out  1  one-cycle synchronous clear request to the parser
- agc_data  out  [5:0][5:0][2:0]  committed frame, same field order
- agc_req  out  1  committed frame pending
- agc_ack  in  1  AGC has consumed agc_data
- err_count  out  8  saturating count of aborted frames
- overrun  out  1  one-cycle pulse: a good frame was dropped because agc_req was still high

## Operation
- Reset values: state IDLE, all counters 0, agc_data 0, agc_req 0, parser_clear 0, overrun 0, err_count 0.
- Byte classes: START '<' (8'd60), OCTAL '0'..'7', SIGN '+'/'-', OTHER.
- FSM states: IDLE, RECV, SETTLE, COMMIT, ABORT.
- IDLE:
  - RX_valid with START → RECV, byte_cnt=1.
  - Any other valid byte is ignored; no error is counted.
- RECV: on RX_valid, check the byte against the expected class for byte_cnt.
  - Positions 1..4 must be OCTAL.
  - For positions p ≥ 5: offset (p-5) mod 6 of 0..4 must be OCTAL, and offset 5 must be SIGN.
  - Mismatch (including a START mid-frame) → ABORT.
  - Match with byte_cnt = FRAME_LEN-1 → SETTLE.
  - Otherwise byte_cnt increments.
- SETTLE: one cycle for the parser registers to settle → COMMIT.
- COMMIT:
  - If agc_req=0: agc_data ← parser_data and agc_req ← 1.
  - If agc_req=1: keep agc_data unchanged and pulse overrun.
  - Either way → IDLE.
- ABORT: assert parser_clear for one cycle, err_count increments (saturates at 255) → IDLE.
- Handshake:
  - agc_req clears on the edge where agc_req=1 and agc_ack=1.
  - agc_data is stable for the whole time agc_req is high.
  - agc_ack while agc_req=0 is ignored.
- Simultaneous set and clear: a clear (ack) in the same cycle as COMMIT applies first. COMMIT therefore sees agc_req=0 and latches the new frame; agc_req stays 1.
- Upstream guarantees at least 4 cycles between RX_valid strobes. A strobe arriving in SETTLE, COMMIT or ABORT is dropped without error.
- Reset mid-frame returns to IDLE immediately. The parser is reset by the same resetn.

## Timing
- The final frame byte is sampled at edge k:
  - SETTLE after k
  - COMMIT after k+1
  - agc_data and agc_req valid after edge k+2
- A bad byte sampled at edge k gives ABORT after k, with parser_clear high and err_count incremented after edge k+1.
- agc_req falls on the edge after agc_ack is sampled high; minimum req pulse is 1 cycle.
- Timeout: idle_cnt resets on every RX_valid in RECV and increments otherwise. At TIMEOUT_CYCLES-1 → ABORT on the next edge.

## Configuration
- RX_TIMEOUT_EN defined: inter-byte watchdog present; a stalled frame aborts after TIMEOUT_CYCLES idle cycles.
- RX_TIMEOUT_EN undefined: no idle counter is built; RECV waits indefinitely, and only a bad character aborts.

## Structure
- Shared package rx_pkg holds:
  - `octal_field_t` (logic [5:0][2:0])
  - the field index constants
  - the ASCII constants
  - the char-class enum
  - the FSM state enum
  - FRAME_LEN
- One sub-module, rx_char_class: combinational classifier from RX_byte to class plus 3-bit octal value. It is shared with `rx_conn`.

## Test plan
- Reset, then a valid 29-byte frame "<6116" + "00012+" + "00100-" + "77777+" + "00000-" → agc_req high 2 cycles after the last byte, with agc_data matching parser_data; err_count 0.
- "<6X" → ABORT, parser_clear pulse 1 cycle, err_count 1, agc_req stays 0.
- Two good frames with no agc_ack between them → first frame held, overrun pulses once, agc_data unchanged.
- agc_ack asserted in the same cycle as COMMIT of a second frame → agc_req stays 1 and agc_data holds the second frame.
- With RX_TIMEOUT_EN and TIMEOUT_CYCLES=16: send "<61" then idle → ABORT 16 cycles after the last byte, err_count increments; without the macro there is no abort.
- 256 malformed frames → err_count saturates at 255; asserting resetn low mid-frame → all outputs zero immediately.

Source files
------------

// File: rtl/rx_pkg.sv
// rx_pkg: shared definitions for the serial DSKY/axis input link.
// Holds the octal field type, field indices, ASCII constants, the
// character-class and frame-FSM enums, and the default frame length.
// The package is shared by rx_conn, rx_char_class and rx_frame_ctrl.
package rx_pkg;

  // A field is six octal digits. VERB and NOUN use only the low two.
  typedef logic [5:0][2:0] octal_field_t;

  localparam int unsigned NUM_FIELDS   = 6;
  localparam int unsigned FIELD_VERB   = 0;
  localparam int unsigned FIELD_NOUN   = 1;
  localparam int unsigned FIELD_AXIG   = 2;
  localparam int unsigned FIELD_AXIRA  = 3;
  localparam int unsigned FIELD_AXIRB  = 4;
  localparam int unsigned FIELD_AXIATX = 5;

  localparam logic [7:0] ASCII_START = 8'd60;  // '<'
  localparam logic [7:0] ASCII_ZERO  = 8'd48;  // '0'
  localparam logic [7:0] ASCII_SEVEN = 8'd55;  // '7'
  localparam logic [7:0] ASCII_PLUS  = 8'd43;  // '+'
  localparam logic [7:0] ASCII_MINUS = 8'd45;  // '-'

  // '<' + VERB(2) + NOUN(2) + 4 axes x (5 digits + sign)
  localparam int unsigned FRAME_LEN     = 29;
  localparam int unsigned HEADER_DIGITS = 4;
  localparam int unsigned AXIS_CHARS    = 6;

  typedef enum logic [1:0] {
    CLS_START = 2'd0,
    CLS_OCTAL = 2'd1,
    CLS_SIGN  = 2'd2,
    CLS_OTHER = 2'd3
  } char_class_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    SETTLE = 3'd2,
    COMMIT = 3'd3,
    ABORT  = 3'd4
  } state_e;

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// rx_frame_ctrl_if: req/ack handshake that hands a committed frame to the
// AGC I/O logic.
//   agc_data : committed frame, fields VERB, NOUN, AXIG, AXIRA, AXIRB, AXIATX
//   agc_req  : committed frame pending (held until acknowledged)
//   agc_ack  : AGC has consumed agc_data
// master = frame controller, slave = AGC I/O side.
interface rx_frame_ctrl_if;
  import rx_pkg::*;

  octal_field_t [NUM_FIELDS-1:0] agc_data;
  logic                          agc_req;
  logic                          agc_ack;

  modport master (output agc_data, output agc_req, input agc_ack);
  modport slave  (input agc_data, input agc_req, output agc_ack);
endinterface

// File: rtl/rx_char_class.sv
// rx_char_class: combinational classifier for one received ASCII byte.
//   char_in : received byte
//   cls     : START '<', OCTAL '0'..'7', SIGN '+'/'-', or OTHER
//   octal   : digit value when cls is OCTAL, otherwise 0
module rx_char_class
  import rx_pkg::*;
(
  input  logic [7:0]  char_in,
  output char_class_e cls,
  output logic [2:0]  octal
);

  always_comb begin
    cls   = CLS_OTHER;
    octal = '0;
    if (char_in == ASCII_START) begin
      cls = CLS_START;
    end else if (char_in >= ASCII_ZERO && char_in <= ASCII_SEVEN) begin
      cls   = CLS_OCTAL;
      octal = char_in[2:0];  // '0' is 8'h30, so the low bits are the digit
    end else if (char_in == ASCII_PLUS || char_in == ASCII_MINUS) begin
      cls = CLS_SIGN;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: frame-level controller for the DSKY/axis input link.
// Checks each frame's character classes and length, clears the parser on
// malformed (or, optionally, stalled) frames, and commits complete frames
// atomically into AGC-visible registers behind a req/ack handshake.
//   clk, resetn  : clock, asynchronous active-low reset
//   RX_byte      : received byte, qualified by RX_valid
//   RX_valid     : one-cycle strobe per byte
//   parser_data  : parser field outputs, sampled on commit
//   parser_clear : one-cycle clear request to the parser
//   agc          : agc_data / agc_req / agc_ack handshake (master side)
//   err_count    : saturating count of aborted frames
//   overrun      : pulse when a good frame is dropped because agc_req was high
// Build option: define RX_TIMEOUT_EN to include the inter-byte watchdog
// (abort after TIMEOUT_CYCLES idle cycles inside a frame).
module rx_frame_ctrl #(
  parameter int unsigned FRAME_LEN      = rx_pkg::FRAME_LEN,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [7:0]             RX_byte,
  input  logic                   RX_valid,
  input  logic [5:0][5:0][2:0]   parser_data,
  output logic                   parser_clear,
  rx_frame_ctrl_if.master        agc,
  output logic [7:0]             err_count,
  output logic                   overrun
);
  import rx_pkg::*;

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_POS   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FIRST_AXIS = CNT_W'(HEADER_DIGITS + 1);
  localparam logic [2:0]       SIGN_SLOT  = 3'(AXIS_CHARS - 1);

  state_e           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [2:0]       slot;      // offset within the current axis field
  char_class_e      cls;
  logic [2:0]       octal;
  logic             expect_sign;
  logic             byte_ok;
  logic             timed_out;

  rx_char_class u_class (
    .char_in (RX_byte),
    .cls     (cls),
    .octal   (octal)
  );

  always_comb begin
    if (cls == CLS_OCTAL) begin
      assert (octal == RX_byte[2:0]);
    end
  end

  // slot tracks (byte_cnt - 5) mod 6 incrementally instead of dividing.
  always_comb begin
    expect_sign = (byte_cnt >= FIRST_AXIS) && (slot == SIGN_SLOT);
    byte_ok     = expect_sign ? (cls == CLS_SIGN) : (cls == CLS_OCTAL);
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  assign timed_out = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt <= '0;
    end else if (state != RECV || RX_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      slot         <= '0;
      parser_clear <= 1'b0;
      overrun      <= 1'b0;
      err_count    <= '0;
      agc.agc_data <= '0;
      agc.agc_req  <= 1'b0;
    end else begin
      parser_clear <= 1'b0;
      overrun      <= 1'b0;
      if (agc.agc_req && agc.agc_ack) begin
        agc.agc_req <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (RX_valid && cls == CLS_START) begin
            state    <= RECV;
            byte_cnt <= CNT_W'(1);
            slot     <= '0;
          end
        end
        RECV: begin
          if (RX_valid) begin
            if (!byte_ok) begin
              state <= ABORT;
            end else if (byte_cnt == LAST_POS) begin
              state <= SETTLE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt >= FIRST_AXIS) begin
                slot <= (slot == SIGN_SLOT) ? 3'd0 : slot + 3'd1;
              end
            end
          end else if (timed_out) begin
            state <= ABORT;
          end
        end
        SETTLE: state <= COMMIT;
        COMMIT: begin
          // An ack in this same cycle frees the slot before the commit.
          if (!agc.agc_req || agc.agc_ack) begin
            agc.agc_data <= parser_data;
            agc.agc_req  <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= IDLE;
        end
        ABORT: begin
          parser_clear <= 1'b1;
          if (err_count != '1) begin
            err_count <= err_count + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: randomized self-checking bench for rx_frame_ctrl.
// Frames are byte queues; a reference model decides each byte's validity
// from the frame layout rules and tracks the expected handshake state,
// error count and overrun behaviour.
module tb_rx_frame_ctrl;

  localparam int unsigned FRAME_LEN = 29;
  localparam int unsigned TIMEOUT   = 16;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [7:0]           RX_byte;
  logic                 RX_valid;
  logic [5:0][5:0][2:0] parser_data;
  logic                 parser_clear;
  logic [7:0]           err_count;
  logic                 overrun;

  rx_frame_ctrl_if agc_bus ();

  rx_frame_ctrl #(
    .FRAME_LEN      (FRAME_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .RX_byte      (RX_byte),
    .RX_valid     (RX_valid),
    .parser_data  (parser_data),
    .parser_clear (parser_clear),
    .agc          (agc_bus),
    .err_count    (err_count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic                 m_req;
  logic [5:0][5:0][2:0] m_data;
  int                   m_err;
  bit                   ack_same;
  logic [7:0]           frame_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_byte  = b;
    RX_valid = 1'b1;
    tick();
    RX_valid = 1'b0;
  endtask

  function automatic bit is_octal(input logic [7:0] b);
    return (b >= 8'd48) && (b <= 8'd55);
  endfunction

  function automatic bit is_sign(input logic [7:0] b);
    return (b == 8'd43) || (b == 8'd45);
  endfunction

  // Layout rule: positions 1..4 octal; from 5 on, every sixth char is a sign.
  function automatic bit byte_expected(input int p, input logic [7:0] b);
    if (p <= 4) return is_octal(b);
    if ((p - 5) % 6 == 5) return is_sign(b);
    return is_octal(b);
  endfunction

  function automatic logic [7:0] good_char(input int p);
    if (p > 4 && (p - 5) % 6 == 5) return ($urandom_range(0, 1) != 0) ? 8'd43 : 8'd45;
    return 8'(8'd48 + $urandom_range(0, 7));
  endfunction

  function automatic logic [7:0] bad_char(input int p);
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom_range(0, 255));
      if (!byte_expected(p, b)) return b;
    end
    return 8'd88;  // 'X' is never legal
  endfunction

  task automatic build_good();
    frame_q = {};
    frame_q.push_back(8'd60);
    for (int p = 1; p < FRAME_LEN; p++) frame_q.push_back(good_char(p));
  endtask

  task automatic build_string(input string s);
    frame_q = {};
    for (int i = 0; i < s.len(); i++) frame_q.push_back(8'(s[i]));
  endtask

  task automatic randomize_parser();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        parser_data[i][j] = 3'($urandom_range(0, 7));
  endtask

  task automatic expect_abort();
    check("clear_early", parser_clear, 1'b0);
    tick();
    m_err = (m_err < 255) ? m_err + 1 : 255;
    check("clear_pulse", parser_clear, 1'b1);
    check("err_count", err_count, m_err);
    check("req_on_abort", agc_bus.agc_req, m_req);
    tick();
    check("clear_end", parser_clear, 1'b0);
  endtask

  task automatic expect_commit();
    logic exp_ovr;
    check("req_settle", agc_bus.agc_req, m_req);
    tick();
    check("req_precommit", agc_bus.agc_req, m_req);
    check("data_precommit", agc_bus.agc_data, m_data);
    if (ack_same) begin
      agc_bus.agc_ack = 1'b1;
      m_req = 1'b0;
    end
    exp_ovr = m_req;
    if (!m_req) begin
      m_data = parser_data;
      m_req  = 1'b1;
    end
    tick();
    agc_bus.agc_ack = 1'b0;
    check("req_commit", agc_bus.agc_req, m_req);
    check("data_commit", agc_bus.agc_data, m_data);
    check("overrun", overrun, exp_ovr);
    tick();
    check("overrun_end", overrun, 1'b0);
  endtask

  task automatic play_frame();
    randomize_parser();
    for (int p = 0; p < frame_q.size(); p++) begin
      gap(3 + int'($urandom_range(0, 2)));
      send_byte(frame_q[p]);
      if (p == 0) continue;
      if (!byte_expected(p, frame_q[p])) begin
        expect_abort();
        return;
      end
      if (p == FRAME_LEN - 1) expect_commit();
    end
  endtask

  task automatic pulse_ack();
    agc_bus.agc_ack = 1'b1;
    tick();
    agc_bus.agc_ack = 1'b0;
    m_req = 1'b0;
    check("req_after_ack", agc_bus.agc_req, 1'b0);
    check("data_after_ack", agc_bus.agc_data, m_data);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    resetn          = 1'b0;
    RX_byte         = '0;
    RX_valid        = 1'b0;
    parser_data     = '0;
    agc_bus.agc_ack = 1'b0;
    ack_same        = 1'b0;
    m_req           = 1'b0;
    m_data          = '0;
    m_err           = 0;
    gap(3);
    check("rst_req", agc_bus.agc_req, 1'b0);
    check("rst_data", agc_bus.agc_data, '0);
    check("rst_err", err_count, 8'd0);
    check("rst_clear", parser_clear, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    resetn = 1'b1;
    gap(2);

    // directed good frame
    build_string("<611600012+00100-77777+00000-");
    play_frame();
    check("err_after_good", err_count, m_err);

    // bad char at position 2
    build_string("<6X");
    play_frame();

    // two good frames with no ack: second is dropped
    pulse_ack();
    build_good(); play_frame();
    build_good(); play_frame();

    // ack coincident with the commit of a second frame
    ack_same = 1'b1;
    build_good(); play_frame();
    ack_same = 1'b0;

    // stalled frame
    build_string("<61");
    play_frame();
`ifdef RX_TIMEOUT_EN
    repeat (TIMEOUT) tick();
    check("to_before", parser_clear, 1'b0);
    tick();
    m_err++;
    check("to_clear", parser_clear, 1'b1);
    check("to_err", err_count, m_err);
    tick();
    check("to_clear_end", parser_clear, 1'b0);
`else
    repeat (40) tick();
    check("no_to_clear", parser_clear, 1'b0);
    check("no_to_err", err_count, m_err);
    gap(1);
    send_byte(8'd88);
    expect_abort();
`endif

    // non-start bytes in IDLE are ignored
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'd60) b = 8'd61;
      gap(3);
      send_byte(b);
      tick();
      check("idle_clear", parser_clear, 1'b0);
    end
    check("idle_err", err_count, m_err);

    // randomized frames, some corrupted, random acks in between
    for (int n = 0; n < 40; n++) begin
      build_good();
      if ($urandom_range(0, 1) != 0) begin
        int p;
        p = int'($urandom_range(1, FRAME_LEN - 1));
        frame_q[p] = bad_char(p);
      end
      ack_same = ($urandom_range(0, 5) == 0);
      play_frame();
      ack_same = 1'b0;
      if ($urandom_range(0, 2) == 0) pulse_ack();
    end

    // error counter saturation
    for (int n = 0; n < 256; n++) begin
      frame_q = {};
      frame_q.push_back(8'd60);
      frame_q.push_back(bad_char(1));
      play_frame();
    end
    check("err_saturated", err_count, m_err);
    check("err_sat_value", err_count, 8'd255);

    // reset mid-frame with a pending request
    pulse_ack();
    build_good(); play_frame();
    build_string("<1");
    play_frame();
    resetn = 1'b0;
    #1;
    m_req  = 1'b0;
    m_data = '0;
    m_err  = 0;
    check("mid_rst_req", agc_bus.agc_req, m_req);
    check("mid_rst_data", agc_bus.agc_data, m_data);
    check("mid_rst_err", err_count, m_err);
    check("mid_rst_clear", parser_clear, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    gap(3);
    resetn = 1'b1;
    build_good(); play_frame();
    check("post_rst_err", err_count, m_err);

    gap(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
